// File: rtl/input_mode_controller.sv
// Keyboard-driven mode controller: decodes PS/2 scan codes into tempo/loop entry,
// cursor moves, track selection and playback requests.
module input_mode_controller #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned BPM_W     = 10,
  parameter int unsigned BPM_MAX   = 300,
  parameter int unsigned LOOP_W    = 7,
  parameter int unsigned LOOP_MAX  = 99,
  parameter int unsigned BLINK_DIV = 1_250_000,
  localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        key_data,
  input  logic              key_valid,
  input  logic              play_done,
  output logic [BPM_W-1:0]  bpm,
  output logic [LOOP_W-1:0] loops,
  output logic [CW-1:0]     channel_sel,
  output logic [3:0]        direction,
  output logic              command,
  output logic              start,
  output logic [5:0]        mode,
  output logic              led_blink
);

  // Accumulator must hold the larger limit times ten plus a digit before saturating.
  localparam int unsigned AccTop = ((BPM_MAX > LOOP_MAX) ? BPM_MAX : LOOP_MAX) * 10 + 9;
  localparam int unsigned AW     = $clog2(AccTop + 1);
  localparam int unsigned DW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StLoop, StBpm, StMove, StChan, StPlay} state_e;

  state_e state_q, state_d;

  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [BPM_W-1:0]  bpm_q, bpm_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [3:0]        dir_q, dir_d;
  logic              cmd_q, cmd_d;
  logic [DW-1:0]     div_q, div_d;
  logic              blink_q, blink_d;

  logic              make;
  logic              digit_hit;
  logic [3:0]        digit_val;
  logic [AW-1:0]     acc_calc;
  logic [AW-1:0]     acc_lim;

  // A make byte is any valid byte that is neither a prefix nor the byte after a break.
  assign make = key_valid && !brk_q && (key_data != 8'hF0) && (key_data != 8'hE0);

  // Scan-code to decimal digit decode.
  always_comb begin
    digit_hit = 1'b1;
    digit_val = 4'd0;
    case (key_data)
      8'h45: digit_val = 4'd0;
      8'h16: digit_val = 4'd1;
      8'h1E: digit_val = 4'd2;
      8'h26: digit_val = 4'd3;
      8'h25: digit_val = 4'd4;
      8'h2E: digit_val = 4'd5;
      8'h36: digit_val = 4'd6;
      8'h3D: digit_val = 4'd7;
      8'h3E: digit_val = 4'd8;
      8'h46: digit_val = 4'd9;
      default: digit_hit = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state decode from make bytes and playback completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (make) begin
          case (key_data)
            8'h4B: state_d = StLoop;
            8'h32: state_d = StBpm;
            8'h3A: state_d = StMove;
            8'h21: state_d = StChan;
            8'h29: if (bpm_q != '0) state_d = StPlay;
            default: ;
          endcase
        end
      end
      StLoop, StBpm, StMove, StChan: begin
        if (make && (key_data == 8'h5A || key_data == 8'h76)) state_d = StIdle;
      end
      StPlay: begin
        if (play_done || (make && key_data == 8'h76)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs derived from the current state and registered pulses.
  always_comb begin
    mode      = 6'b000001;
    start     = 1'b0;
    led_blink = blink_q;
    case (state_q)
      StLoop: mode = 6'b000010;
      StBpm:  mode = 6'b000100;
      StMove: mode = 6'b001000;
      StChan: mode = 6'b010000;
      StPlay: begin
        mode      = 6'b100000;
        start     = 1'b1;
        led_blink = 1'b1;
      end
      default: begin
        mode      = 6'b000001;
        led_blink = 1'b0;
      end
    endcase
    bpm         = bpm_q;
    loops       = loops_q;
    channel_sel = chan_q;
    direction   = dir_q;
    command     = cmd_q;
  end

  // Datapath next-state: prefix flags, accumulator, committed values, pulses, blink divider.
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    acc_d   = acc_q;
    bpm_d   = bpm_q;
    loops_d = loops_q;
    chan_d  = chan_q;
    dir_d   = 4'b0000;
    cmd_d   = 1'b0;
    div_d   = div_q;
    blink_d = blink_q;

    acc_calc = (acc_q << 3) + (acc_q << 1) + AW'(digit_val);
    acc_lim  = (state_q == StLoop) ? AW'(LOOP_MAX) : AW'(BPM_MAX);

    if (key_valid) begin
      if (brk_q) begin
        // Byte after a break is the released key; a second 0xF0 keeps the break pending.
        brk_d = (key_data == 8'hF0);
        ext_d = 1'b0;
      end else if (key_data == 8'hF0) begin
        brk_d = 1'b1;
      end else if (key_data == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        ext_d = 1'b0;
      end
    end

    if (make) begin
      case (state_q)
        StIdle: begin
          if (key_data == 8'h4B || key_data == 8'h32) acc_d = '0;
        end
        StLoop, StBpm: begin
          if (digit_hit) begin
            acc_d = (acc_calc > acc_lim) ? acc_lim : acc_calc;
          end else if (key_data == 8'h66) begin
            acc_d = acc_q / AW'(10);
          end else if (key_data == 8'h5A) begin
            if (state_q == StLoop) loops_d = LOOP_W'(acc_q);
            else                   bpm_d   = BPM_W'(acc_q);
          end
        end
        StMove: begin
          if (ext_q) begin
            case (key_data)
              8'h75: dir_d = 4'b1000;
              8'h72: dir_d = 4'b0100;
              8'h6B: dir_d = 4'b0010;
              8'h74: dir_d = 4'b0001;
              default: ;
            endcase
          end
          if (key_data == 8'h29) cmd_d = 1'b1;
        end
        StChan: begin
          if (digit_hit && digit_val != 4'd0 && 32'(digit_val) <= CHANNELS) begin
            chan_d = CW'(digit_val - 4'd1);
          end
        end
        default: ;
      endcase
    end

    if (state_d != state_q) begin
      div_d   = '0;
      blink_d = 1'b0;
    end else if (state_q == StLoop || state_q == StBpm || state_q == StMove ||
                 state_q == StChan) begin
      if (32'(div_q) >= BLINK_DIV - 1) begin
        div_d   = '0;
        blink_d = ~blink_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d   = '0;
      blink_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      acc_q   <= '0;
      bpm_q   <= '0;
      loops_q <= '0;
      chan_q  <= '0;
      dir_q   <= 4'b0000;
      cmd_q   <= 1'b0;
      div_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      acc_q   <= acc_d;
      bpm_q   <= bpm_d;
      loops_q <= loops_d;
      chan_q  <= chan_d;
      dir_q   <= dir_d;
      cmd_q   <= cmd_d;
      div_q   <= div_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: tb/tb_input_mode_controller.sv
// Directed bench for input_mode_controller with a short blink period.
module tb_input_mode_controller;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] key_data;
  logic       key_valid;
  logic       play_done;
  logic [9:0] bpm;
  logic [6:0] loops;
  logic [1:0] channel_sel;
  logic [3:0] direction;
  logic       command;
  logic       start;
  logic [5:0] mode;
  logic       led_blink;

  int checks = 0;
  int errors = 0;

  input_mode_controller #(
    .CHANNELS (4),
    .BPM_W    (10),
    .BPM_MAX  (300),
    .LOOP_W   (7),
    .LOOP_MAX (99),
    .BLINK_DIV(4)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .play_done  (play_done),
    .bpm        (bpm),
    .loops      (loops),
    .channel_sel(channel_sel),
    .direction  (direction),
    .command    (command),
    .start      (start),
    .mode       (mode),
    .led_blink  (led_blink)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the falling edge after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    key_data  = b;
    key_valid = 1'b1;
    @(negedge CLOCK_50);
    key_valid = 1'b0;
    key_data  = 8'h00;
  endtask

  initial begin
    reset     = 1'b1;
    key_data  = 8'h00;
    key_valid = 1'b0;
    play_done = 1'b0;
    #12;
    check("rst_mode", 32'(mode), 32'h01);
    check("rst_bpm", 32'(bpm), 0);
    check("rst_loops", 32'(loops), 0);
    check("rst_chan", 32'(channel_sel), 0);
    check("rst_dir", 32'(direction), 0);
    check("rst_cmd", 32'(command), 0);
    check("rst_start", 32'(start), 0);
    check("rst_led", 32'(led_blink), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Play refused while bpm is zero.
    send(8'h29);
    check("play_bpm0_mode", 32'(mode), 32'h01);
    check("play_bpm0_start", 32'(start), 0);

    // Tempo entry 1,7,0 -> 170.
    send(8'h32);
    check("bpm_mode", 32'(mode), 32'h04);
    send(8'h16);
    send(8'h3D);
    send(8'h45);
    check("bpm_uncommitted", 32'(bpm), 0);
    send(8'h5A);
    check("bpm_commit_mode", 32'(mode), 32'h01);
    check("bpm_commit", 32'(bpm), 170);

    // Playback, ended by play_done.
    send(8'h29);
    check("play_mode", 32'(mode), 32'h20);
    check("play_start", 32'(start), 1);
    check("play_led", 32'(led_blink), 1);
    send(8'h76 & 8'h00);
    check("play_ignore_key", 32'(mode), 32'h20);
    @(negedge CLOCK_50);
    play_done = 1'b1;
    @(negedge CLOCK_50);
    play_done = 1'b0;
    check("done_mode", 32'(mode), 32'h01);
    check("done_start", 32'(start), 0);

    // Playback, ended by Esc.
    send(8'h29);
    check("play2_start", 32'(start), 1);
    send(8'h76);
    check("esc_play_mode", 32'(mode), 32'h01);
    check("esc_play_start", 32'(start), 0);

    // Loops: 2,4,backspace,9 -> 29.
    send(8'h4B);
    check("loop_mode", 32'(mode), 32'h02);
    send(8'h1E);
    send(8'h25);
    send(8'h66);
    send(8'h46);
    send(8'h5A);
    check("loops_29", 32'(loops), 29);
    // 9,9,9 saturates at 99.
    send(8'h4B);
    send(8'h46);
    send(8'h46);
    send(8'h46);
    send(8'h5A);
    check("loops_sat", 32'(loops), 99);
    // Esc abandons entry.
    send(8'h4B);
    send(8'h16);
    send(8'h76);
    check("loops_esc_mode", 32'(mode), 32'h01);
    check("loops_esc", 32'(loops), 99);
    // Backspace at zero stays zero, then commit zero.
    send(8'h4B);
    send(8'h66);
    send(8'h5A);
    check("loops_bs_zero", 32'(loops), 0);

    // Move mode and blink divider: toggles on the fourth edge after entry.
    send(8'h3A);
    check("move_mode", 32'(mode), 32'h08);
    check("move_led0", 32'(led_blink), 0);
    repeat (3) @(negedge CLOCK_50);
    check("move_led_pre", 32'(led_blink), 0);
    @(negedge CLOCK_50);
    check("move_led_tog", 32'(led_blink), 1);

    send(8'hE0);
    send(8'h75);
    check("dir_up", 32'(direction), 32'h8);
    @(negedge CLOCK_50);
    check("dir_up_clear", 32'(direction), 0);
    send(8'h75);
    check("dir_no_ext", 32'(direction), 0);
    send(8'hE0);
    send(8'h6B);
    check("dir_left", 32'(direction), 32'h2);
    send(8'hF0);
    send(8'h29);
    check("break_no_cmd", 32'(command), 0);
    send(8'h29);
    check("cmd_pulse", 32'(command), 1);
    @(negedge CLOCK_50);
    check("cmd_clear", 32'(command), 0);
    send(8'h76);
    check("move_esc", 32'(mode), 32'h01);

    // Channel select.
    send(8'h21);
    check("chan_mode", 32'(mode), 32'h10);
    send(8'h1E);
    check("chan_2", 32'(channel_sel), 1);
    send(8'h2E);
    check("chan_5_ignored", 32'(channel_sel), 1);
    send(8'h25);
    check("chan_4", 32'(channel_sel), 3);
    send(8'h5A);
    check("chan_exit", 32'(mode), 32'h01);

    // Reset mid tempo entry.
    send(8'h32);
    send(8'h16);
    send(8'h1E);
    #2;
    reset = 1'b1;
    #1;
    check("arst_mode", 32'(mode), 32'h01);
    check("arst_bpm", 32'(bpm), 0);
    check("arst_loops", 32'(loops), 0);
    check("arst_chan", 32'(channel_sel), 0);
    check("arst_led", 32'(led_blink), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    send(8'h5A);
    check("arst_no_commit", 32'(bpm), 0);
    check("arst_idle", 32'(mode), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
